// File: rtl/pio_btn_pkg.sv
// Shared definitions for the button PIO event master: register offsets, mask value, FSM states.
// HOLD and CLR2 exist only when PIO_BTN_HOLDOFF_EN is defined.
package pio_btn_pkg;

   localparam logic [1:0]  PIO_ADDR_DATA = 2'd0;
   localparam logic [1:0]  PIO_ADDR_MASK = 2'd2;
   localparam logic [1:0]  PIO_ADDR_CAP  = 2'd3;
   localparam logic [31:0] PIO_MASK_ALL  = 32'd1;

   typedef enum logic [3:0] {
      ST_ARM,
      ST_IDLE,
      ST_RD_CAP,
      ST_CAP_WAIT,
      ST_CLR,
      ST_RD_DAT,
      ST_DAT_WAIT,
      ST_EMIT
`ifdef PIO_BTN_HOLDOFF_EN
      ,
      ST_HOLD,
      ST_CLR2
`endif
   } pio_btn_state_t;

endpackage

// File: rtl/pio_btn_event_master.sv
// Avalon-MM initiator servicing an edge-capturing button PIO and emitting one event per press.
// Optional debounce hold-off (HOLD/CLR2 states) is built when PIO_BTN_HOLDOFF_EN is defined.
module pio_btn_event_master
   import pio_btn_pkg::*;
#(
   parameter int HOLDOFF_CYCLES = 500000,
   parameter int HOLD_W         = $clog2(HOLDOFF_CYCLES + 1)
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        irq,
   input  logic [31:0] readdata,
   output logic [1:0]  address,
   output logic        chipselect,
   output logic        write_n,
   output logic [31:0] writedata,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic        evt_level,
   output logic [15:0] evt_count
);

   pio_btn_state_t state;
   pio_btn_state_t state_nx;

   logic [1:0]  address_d;
   logic        chipselect_d;
   logic        write_n_d;
   logic [31:0] writedata_d;
   logic        evt_valid_d;
   logic        evt_level_d;
   logic [15:0] evt_count_d;
   logic        handshake;
   logic        unused_bits;

   assign handshake = (state == ST_EMIT) && evt_valid && evt_ready;

`ifdef PIO_BTN_HOLDOFF_EN
   logic [HOLD_W-1:0] hold_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_cnt <= '0;
      end else if (handshake) begin
         hold_cnt <= HOLD_W'(HOLDOFF_CYCLES - 1);
      end else if (state == ST_HOLD && hold_cnt != '0) begin
         hold_cnt <= hold_cnt - 1'b1;
      end
   end

   assign unused_bits = ^readdata[31:1];
`else
   assign unused_bits = ^{readdata[31:1], (HOLDOFF_CYCLES > 0), (HOLD_W > 0)};
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= ST_ARM;
      end else begin
         state <= state_nx;
      end
   end

   // ARM lingers until its write has been on the bus for one cycle, so the
   // mask write lands in the first cycle after reset release.
   always_comb begin
      state_nx = state;
      case (state)
         ST_ARM:      state_nx = chipselect ? ST_IDLE : ST_ARM;
         ST_IDLE:     if (irq && enable) state_nx = ST_RD_CAP;
         ST_RD_CAP:   state_nx = ST_CAP_WAIT;
         ST_CAP_WAIT: state_nx = readdata[0] ? ST_CLR : ST_IDLE;
         ST_CLR:      state_nx = ST_RD_DAT;
         ST_RD_DAT:   state_nx = ST_DAT_WAIT;
         ST_DAT_WAIT: state_nx = ST_EMIT;
`ifdef PIO_BTN_HOLDOFF_EN
         ST_EMIT:     if (handshake) state_nx = ST_HOLD;
         ST_HOLD:     if (hold_cnt == '0) state_nx = ST_CLR2;
         ST_CLR2:     state_nx = ST_IDLE;
`else
         ST_EMIT:     if (handshake) state_nx = ST_IDLE;
`endif
         default:     state_nx = ST_ARM;
      endcase
   end

   // Outputs are registered from the next state so each bus phase lines up
   // with the cycle its state occupies.
   always_comb begin
      chipselect_d = 1'b0;
      write_n_d    = 1'b1;
      address_d    = address;
      writedata_d  = writedata;
      case (state_nx)
         ST_ARM: begin
            chipselect_d = 1'b1;
            write_n_d    = 1'b0;
            address_d    = PIO_ADDR_MASK;
            writedata_d  = PIO_MASK_ALL;
         end
         ST_RD_CAP: begin
            chipselect_d = 1'b1;
            address_d    = PIO_ADDR_CAP;
         end
`ifdef PIO_BTN_HOLDOFF_EN
         ST_CLR, ST_CLR2: begin
`else
         ST_CLR: begin
`endif
            chipselect_d = 1'b1;
            write_n_d    = 1'b0;
            address_d    = PIO_ADDR_CAP;
            writedata_d  = 32'd0;
         end
         ST_RD_DAT: begin
            chipselect_d = 1'b1;
            address_d    = PIO_ADDR_DATA;
         end
         default: ;
      endcase
      evt_valid_d = (state_nx == ST_EMIT);
      evt_level_d = (state == ST_DAT_WAIT) ? readdata[0] : evt_level;
      evt_count_d = handshake ? evt_count + 16'd1 : evt_count;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         address    <= 2'd0;
         chipselect <= 1'b0;
         write_n    <= 1'b1;
         writedata  <= 32'd0;
         evt_valid  <= 1'b0;
         evt_level  <= 1'b0;
         evt_count  <= 16'd0;
      end else begin
         address    <= address_d;
         chipselect <= chipselect_d;
         write_n    <= write_n_d;
         writedata  <= writedata_d;
         evt_valid  <= evt_valid_d;
         evt_level  <= evt_level_d;
         evt_count  <= evt_count_d;
      end
   end

endmodule

// File: tb/tb_pio_btn_event_master.sv
// Directed bench for pio_btn_event_master with a small edge-capturing PIO slave model.
// Hold-off expectations apply when PIO_BTN_HOLDOFF_EN is defined.
module tb_pio_btn_event_master;
   import pio_btn_pkg::*;

   localparam int HOLD = 8;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        irq;
   logic [31:0] readdata = 32'd0;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic        evt_valid;
   logic        evt_ready;
   logic        evt_level;
   logic [15:0] evt_count;

   always #5 clk = ~clk;

   pio_btn_event_master #(.HOLDOFF_CYCLES(HOLD)) dut (
      .clk(clk), .reset_n(reset_n), .enable(enable), .irq(irq),
      .readdata(readdata), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_level(evt_level), .evt_count(evt_count)
   );

   // PIO slave model with a transaction log {write_n, address, write data}
   logic        edge_cap = 1'b0;
   logic        pin;
   logic        btn_edge;
   logic [31:0] mask_reg = 32'd0;
   logic [34:0] tx_log [0:63];
   int          n_tx = 0;

   always @(posedge clk) begin
      if (chipselect === 1'b1) begin
         tx_log[n_tx[5:0]] <= {write_n, address, (write_n ? 32'd0 : writedata)};
         n_tx <= n_tx + 1;
         if (write_n) begin
            case (address)
               PIO_ADDR_DATA: readdata <= {31'd0, pin};
               PIO_ADDR_MASK: readdata <= mask_reg;
               PIO_ADDR_CAP:  readdata <= {31'd0, edge_cap};
               default:       readdata <= 32'd0;
            endcase
         end else if (address == PIO_ADDR_MASK) begin
            mask_reg <= writedata;
         end
      end
      if (btn_edge) edge_cap <= 1'b1;
      else if (chipselect === 1'b1 && !write_n && address == PIO_ADDR_CAP) edge_cap <= 1'b0;
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  n0;
      int  n1;
      logic seen;
      logic stable;
      logic got;

      reset_n = 1'b0; enable = 1'b1; irq = 1'b0; evt_ready = 1'b1;
      pin = 1'b0; btn_edge = 1'b0;
      step(3);
      chk("rst_cs", chipselect, 0);
      chk("rst_wn", write_n, 1);
      chk("rst_addr", address, 0);
      chk("rst_wd", writedata, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_level", evt_level, 0);
      chk("rst_count", evt_count, 0);

      reset_n = 1'b1;
      step(1);
      chk("arm_cs", chipselect, 1);
      chk("arm_wn", write_n, 0);
      chk("arm_addr", address, 2);
      chk("arm_wd", writedata, 1);
      step(1);
      chk("idle_cs", chipselect, 0);
      chk("idle_valid", evt_valid, 0);
      chk("mask_reg", mask_reg, 1);

      // Normal press: capture=1, pin=1
      pin = 1'b1; btn_edge = 1'b1;
      step(1);
      btn_edge = 1'b0; irq = 1'b1; n0 = n_tx;
      step(1);
      irq = 1'b0;
      chk("rdcap_cs", chipselect, 1);
      chk("rdcap_addr", address, 3);
      chk("rdcap_wn", write_n, 1);
      step(4);
      chk("t5_valid", evt_valid, 0);
      step(1);
      chk("t6_valid", evt_valid, 1);
      chk("t6_level", evt_level, 1);
      chk("t6_count", evt_count, 0);
      step(1);
      chk("t7_valid", evt_valid, 0);
      chk("t7_count", evt_count, 1);
      chk("svc_ntx", n_tx - n0, 3);
      chk("svc_tx0", tx_log[n0[5:0]], {1'b1, 2'd3, 32'd0});
      chk("svc_tx1", tx_log[n0[5:0] + 6'd1], {1'b0, 2'd3, 32'd0});
      chk("svc_tx2", tx_log[n0[5:0] + 6'd2], {1'b1, 2'd0, 32'd0});
      chk("svc_cap_clr", edge_cap, 0);
`ifdef PIO_BTN_HOLDOFF_EN
      n1 = n_tx; seen = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
         if (i > 0) step(1);
         if (chipselect !== 1'b0) seen = 1'b1;
         if (i == 1) begin btn_edge = 1'b1; irq = 1'b1; end
         if (i == 2) btn_edge = 1'b0;
      end
      chk("hold_quiet", seen, 0);
      chk("hold_ntx", n_tx - n1, 0);
      step(1);
      chk("clr2_cs", chipselect, 1);
      chk("clr2_wn", write_n, 0);
      chk("clr2_addr", address, 3);
      chk("clr2_wd", writedata, 0);
      step(1);
      irq = 1'b0;
      chk("clr2_discard", edge_cap, 0);
      step(8);
      chk("hold_count", evt_count, 1);
      chk("hold_valid", evt_valid, 0);
`endif

      // Spurious interrupt: capture=0
      pin = 1'b0; irq = 1'b1; n0 = n_tx;
      step(1);
      irq = 1'b0;
      step(2);
      chk("spur_idle", dut.state, ST_IDLE);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step(1);
         if (evt_valid !== 1'b0) seen = 1'b1;
      end
      chk("spur_valid", seen, 0);
      chk("spur_ntx", n_tx - n0, 1);
      chk("spur_tx0", tx_log[n0[5:0]], {1'b1, 2'd3, 32'd0});
      chk("spur_count", evt_count, 1);

      // Back-pressure with a second press arriving during the stall
      evt_ready = 1'b0; pin = 1'b0; btn_edge = 1'b1;
      step(1);
      btn_edge = 1'b0; irq = 1'b1;
      step(1);
      irq = 1'b0;
      step(5);
      chk("bp_valid", evt_valid, 1);
      chk("bp_level", evt_level, 0);
      chk("bp_count", evt_count, 1);
      n1 = n_tx; stable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (evt_valid !== 1'b1 || evt_level !== 1'b0 || evt_count !== 16'd1) stable = 1'b0;
         if (i == 5) begin pin = 1'b1; btn_edge = 1'b1; irq = 1'b1; end
         if (i == 6) btn_edge = 1'b0;
      end
      chk("bp_stable", stable, 1);
      chk("bp_quiet", n_tx - n1, 0);
      evt_ready = 1'b1;
      step(1);
      chk("bp_count2", evt_count, 2);
      chk("bp_valid2", evt_valid, 0);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         if (chipselect === 1'b1 && write_n === 1'b1 && address === 2'd3) got = 1'b1;
         else step(1);
      end
      chk("bp_second_start", got, 1);
      irq = 1'b0;
      step(10);
`ifdef PIO_BTN_HOLDOFF_EN
      chk("bp_final_count", evt_count, 2);
      chk("bp_final_level", evt_level, 0);
`else
      chk("bp_final_count", evt_count, 3);
      chk("bp_final_level", evt_level, 1);
`endif

      // enable low blocks service
      enable = 1'b0; irq = 1'b1; n0 = n_tx;
      step(6);
      chk("en_quiet", n_tx - n0, 0);
      irq = 1'b0; enable = 1'b1;
      step(2);

      // Reset pulse during RD_DAT
      pin = 1'b1; btn_edge = 1'b1;
      step(1);
      btn_edge = 1'b0; irq = 1'b1;
      step(1);
      irq = 1'b0;
      step(3);
      chk("rddat_cs", chipselect, 1);
      chk("rddat_addr", address, 0);
      chk("rddat_wn", write_n, 1);
      reset_n = 1'b0;
      step(1);
      chk("mrst_cs", chipselect, 0);
      chk("mrst_count", evt_count, 0);
      chk("mrst_valid", evt_valid, 0);
      reset_n = 1'b1;
      step(1);
      chk("rearm_cs", chipselect, 1);
      chk("rearm_wn", write_n, 0);
      chk("rearm_addr", address, 2);
      chk("rearm_wd", writedata, 1);
      step(1);
      chk("rearm_done", chipselect, 0);
      step(4);
      chk("rearm_idle", dut.state, ST_IDLE);
      chk("rearm_novalid", evt_valid, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
